tilelink_a_arbiter: RTL

- Merges four upstream TileLink A-channel masters (L1Ds, L1Is) into one A stream toward the broadcaster/L2 memory side.
- Tags each request with a 2-bit source ID, arbitrates round-robin, and locks the grant across multi-beat data bursts.
- Routes returning D-channel beats back to the originating master by source ID.
- A path has a single registered output stage; the D path is combinational.

---
 rtl/tl_pkg.sv | 37 +++
 rtl/rr_arbiter4.sv | 37 +++
 rtl/tilelink_a_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : tl_pkg
// Brief    : TileLink A-channel opcode encoding, beat size and beat counting
//            shared by the A-channel arbiter and its sub-modules.
// Revision : 1.0 - initial release
// ============================================================================
package tl_pkg;

    typedef enum logic [2:0] {
        PutFull      = 3'd0,
        PutPartial   = 3'd1,
        Arith        = 3'd2,
        Logical      = 3'd3,
        Get          = 3'd4,
        Intent       = 3'd5,
        AcquireBlock = 3'd6,
        AcquirePerm  = 3'd7
    } tl_a_opcode_e;

    localparam int BEAT_BYTES = 16;

    // Number of A beats a message occupies. Only opcodes 0-3 carry data, so
    // opcode bit 2 set means a single header-only beat. Data messages span
    // 2^size bytes split over 16-byte beats.
    function automatic logic [3:0] tl_beats(input logic [2:0] opcode,
                                            input logic [2:0] size);
        logic [3:0] beats;
        beats = 4'd1;
        if (!opcode[2] && (size > 3'd4)) begin
            beats = 4'd1 << (size - 3'd4);
        end
        return beats;
    endfunction

endpackage : tl_pkg
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4
// Brief    : Combinational 4-way round-robin picker. Grants the first
//            requester found searching upward from the pointer, mod 4.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [3:0] o_grant,
    output logic [1:0] o_grant_idx,
    output logic       o_grant_any
);

    logic [1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_grant     = 4'b0000;
        o_grant_idx = 2'd0;
        o_grant_any = 1'b0;
        w_idx       = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            w_idx = i_ptr + 2'(i);
            if (i_req[w_idx]) begin
                o_grant_idx = w_idx;
                o_grant_any = 1'b1;
            end
        end
        if (o_grant_any) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

endmodule : rr_arbiter4
`default_nettype wire

// File: rtl/tilelink_a_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tilelink_a_arbiter
// Brief    : Merges four TileLink A-channel masters into one registered A
//            stream with round-robin arbitration and burst locking; routes
//            D-channel beats back to the requester by source ID.
// Revision : 1.0 - initial release
// ============================================================================
module tilelink_a_arbiter
    import tl_pkg::*;
#(
    parameter int NUM_M  = 4,
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int SRC_W  = 2
) (
    input  logic                  tilelink_clk_i,
    input  logic                  tilelink_rst_ni,
    input  logic [2:0]            m_a_opcode_i  [NUM_M],
    input  logic [2:0]            m_a_param_i   [NUM_M],
    input  logic [2:0]            m_a_size_i    [NUM_M],
    input  logic [ADDR_W-1:0]     m_a_address_i [NUM_M],
    input  logic [BEAT_BYTES-1:0] m_a_mask_i    [NUM_M],
    input  logic [DATA_W-1:0]     m_a_data_i    [NUM_M],
    input  logic [NUM_M-1:0]      m_a_corrupt_i,
    input  logic [NUM_M-1:0]      m_a_valid_i,
    output logic [NUM_M-1:0]      m_a_ready_o,
    output logic [2:0]            s_a_opcode_o,
    output logic [2:0]            s_a_param_o,
    output logic [2:0]            s_a_size_o,
    output logic [SRC_W-1:0]      s_a_source_o,
    output logic [ADDR_W-1:0]     s_a_address_o,
    output logic [BEAT_BYTES-1:0] s_a_mask_o,
    output logic [DATA_W-1:0]     s_a_data_o,
    output logic                  s_a_corrupt_o,
    output logic                  s_a_valid_o,
    input  logic                  s_a_ready_i,
    input  logic [2:0]            s_d_opcode_i,
    input  logic [2:0]            s_d_param_i,
    input  logic [2:0]            s_d_size_i,
    input  logic [SRC_W-1:0]      s_d_source_i,
    input  logic                  s_d_denied_i,
    input  logic                  s_d_corrupt_i,
    input  logic                  s_d_valid_i,
    input  logic [DATA_W-1:0]     s_d_data_i,
    output logic                  s_d_ready_o,
    output logic [2:0]            m_d_opcode_o  [NUM_M],
    output logic [2:0]            m_d_param_o   [NUM_M],
    output logic [2:0]            m_d_size_o    [NUM_M],
    output logic [NUM_M-1:0]      m_d_denied_o,
    output logic [DATA_W-1:0]     m_d_data_o    [NUM_M],
    output logic [NUM_M-1:0]      m_d_corrupt_o,
    output logic [NUM_M-1:0]      m_d_valid_o,
    input  logic [NUM_M-1:0]      m_d_ready_i
);

    // Control state
    logic                  r_valid;
    logic [SRC_W-1:0]      r_ptr;
    logic                  r_lock;
    logic [SRC_W-1:0]      r_lock_id;
    logic [3:0]            r_cnt;

    // Output payload register
    logic [2:0]            r_opcode;
    logic [2:0]            r_param;
    logic [2:0]            r_size;
    logic [SRC_W-1:0]      r_source;
    logic [ADDR_W-1:0]     r_address;
    logic [BEAT_BYTES-1:0] r_mask;
    logic [DATA_W-1:0]     r_data;
    logic                  r_corrupt;

    logic [NUM_M-1:0]      w_arb_grant;
    logic [SRC_W-1:0]      w_arb_idx;
    logic                  w_arb_any;
    logic                  w_load_en;
    logic [SRC_W-1:0]      w_sel_idx;
    logic                  w_sel_valid;
    logic [NUM_M-1:0]      w_rdy_oh;
    logic                  w_accept;
    logic [3:0]            w_beats;

    rr_arbiter4 u_rr_arbiter4 (
        .i_req       (m_a_valid_i),
        .i_ptr       (r_ptr),
        .o_grant     (w_arb_grant),
        .o_grant_idx (w_arb_idx),
        .o_grant_any (w_arb_any)
    );

    // The output register can take a new beat when empty or being drained.
    assign w_load_en   = !r_valid || s_a_ready_i;

    // A locked burst owns the grant even while its master is idle.
    assign w_sel_idx   = r_lock ? r_lock_id : w_arb_idx;
    assign w_sel_valid = r_lock ? m_a_valid_i[r_lock_id] : w_arb_any;
    assign w_rdy_oh    = r_lock ? (NUM_M'(1) << r_lock_id) : w_arb_grant;

    assign m_a_ready_o = w_rdy_oh & {NUM_M{tilelink_rst_ni && w_load_en}};
    assign w_accept    = tilelink_rst_ni && w_load_en && w_sel_valid;
    assign w_beats     = tl_beats(m_a_opcode_i[w_sel_idx], m_a_size_i[w_sel_idx]);

    // Output-valid flag, round-robin pointer and burst lock/beat counter.
    always_ff @(posedge tilelink_clk_i) begin
        if (!tilelink_rst_ni) begin
            r_valid   <= 1'b0;
            r_ptr     <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
            r_cnt     <= 4'd0;
        end else begin
            if (w_load_en) begin
                r_valid <= w_accept;
            end
            if (w_accept) begin
                if (r_lock) begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_lock <= 1'b0;
                    end
                end else begin
                    r_ptr <= w_sel_idx + SRC_W'(1);
                    if (w_beats > 4'd1) begin
                        r_lock    <= 1'b1;
                        r_lock_id <= w_sel_idx;
                        r_cnt     <= w_beats - 4'd1;
                    end
                end
            end
        end
    end

    // Payload register; contents only matter while r_valid is set.
    always_ff @(posedge tilelink_clk_i) begin
        if (w_accept) begin
            r_opcode  <= m_a_opcode_i[w_sel_idx];
            r_param   <= m_a_param_i[w_sel_idx];
            r_size    <= m_a_size_i[w_sel_idx];
            r_source  <= w_sel_idx;
            r_address <= m_a_address_i[w_sel_idx];
            r_mask    <= m_a_mask_i[w_sel_idx];
            r_data    <= m_a_data_i[w_sel_idx];
            r_corrupt <= m_a_corrupt_i[w_sel_idx];
        end
    end

    assign s_a_valid_o   = r_valid;
    assign s_a_opcode_o  = r_opcode;
    assign s_a_param_o   = r_param;
    assign s_a_size_o    = r_size;
    assign s_a_source_o  = r_source;
    assign s_a_address_o = r_address;
    assign s_a_mask_o    = r_mask;
    assign s_a_data_o    = r_data;
    assign s_a_corrupt_o = r_corrupt;

    // D channel: broadcast the payload, steer valid by source ID.
    generate
        for (genvar k = 0; k < NUM_M; k++) begin : g_d_route
            assign m_d_valid_o[k]   = s_d_valid_i && (s_d_source_i == SRC_W'(k));
            assign m_d_opcode_o[k]  = s_d_opcode_i;
            assign m_d_param_o[k]   = s_d_param_i;
            assign m_d_size_o[k]    = s_d_size_i;
            assign m_d_denied_o[k]  = s_d_denied_i;
            assign m_d_data_o[k]    = s_d_data_i;
            assign m_d_corrupt_o[k] = s_d_corrupt_i;
        end
    endgenerate

    assign s_d_ready_o = m_d_ready_i[s_d_source_i];

endmodule : tilelink_a_arbiter
`default_nettype wire
